tl_inflight_monitor: RTL and testbench
======================================

// Module: tl_inflight_monitor
// PURPOSE
//  Parametrised TileLink-UL protocol monitor for one A/D link pair, placed beside a TL edge in the testbench wrapper.
//  Tracks every outstanding request per source ID, checks A-channel stall stability, opcode legality, alignment and burst consistency.
//  Checks that each D response matches its request; adds a no-progress watchdog. Reports via error pulse, sticky flags and optional $fatal.
// PARAMETERS
//  SOURCE_W   4     source ID width; the tracking table has 2**SOURCE_W entries
//  ADDR_W     30    a_address width
//  SIZE_W     3     a_size/d_size width (log2 bytes)
//  LG_BEAT    2     log2 bytes per data beat
//  TIMEOUT    1024  cycles without D progress while inflight>0 before error 9; 0 disables the watchdog
//  FATAL_EN   1     1: $fatal on any error (ifndef SYNTHESIS)
// PORTS
//  clock            in   1         rising-edge clock
//  reset_n          in   1         asynchronous active-low reset
//  a_valid/a_ready  in   1/1       A handshake; fire = valid&ready
//  a_opcode         in   3         legal: 0 PutFull, 1 PutPartial, 4 Get
//  a_size           in   SIZE_W    log2 transfer bytes
//  a_source         in   SOURCE_W  request ID
//  a_address        in   ADDR_W    byte address
//  d_valid/d_ready  in   1/1       D handshake
//  d_opcode         in   3         0 AccessAck, 1 AccessAckData
//  d_size           in   SIZE_W    must equal request size
//  d_source         in   SOURCE_W  response ID
//  clear            in   1         clears err_flags and err_count
//  err_valid        out  1         one-cycle pulse, registered
//  err_code         out  4         lowest-numbered error seen this cycle
//  err_source       out  SOURCE_W  source of the reported error
//  err_flags        out  9         sticky; bit k-1 = code k
//  err_count        out  16        saturating error-cycle count
//  inflight_count   out  SOURCE_W+1  outstanding requests
// BEHAVIOUR
//  Reset: all outputs 0, table invalid, beat counters 0, watchdog 0, A-hold register invalid.
//  Beats: beats(size) = 1 if size<=LG_BEAT, else 1<<(size-LG_BEAT). Put A and AccessAckData D are multi-beat; Get A and AccessAck D are 1 beat.
//  Allocation: the first A beat fire sets entry[source] = {valid, size, expect_data = (opcode==Get)}.
//  Retirement: the last D beat fire clears the entry.
//  Same cycle, same source, D last beat and A first beat: retire, then allocate. No error.
//  Error codes, checked on the cycle and registered for the outputs the next cycle:
//   1 A_STALL:  A was valid&!ready last cycle, and now a_valid=0 or opcode/size/source/address changed.
//   2 A_OPCODE: A first beat with an opcode not in {0,1,4}.
//   3 A_ALIGN:  a_address[size-1:0] != 0 on the first beat.
//   4 A_DUP:    first-beat source is already valid and is not retiring this cycle.
//   5 A_BURST:  a mid-burst A beat whose opcode/size/source differs from beat 0.
//   6 D_UNSOL:  D first beat for a source whose entry is invalid.
//   7 D_MISMATCH: d_size!=entry.size, or d_opcode!=(expect_data?1:0).
//   8 D_BURST:  a mid-burst D beat whose opcode/size/source differs from beat 0.
//   9 TIMEOUT:  wd counter reaches TIMEOUT. The counter increments while inflight_count>0 and no D fire occurs; it resets to 0 on any D fire or when inflight_count=0. After firing it reloads 0.
//  Error checks apply only on fire, except A_STALL and TIMEOUT.
//  A-opcode, A-align and A-dup errors still allocate the entry; D-unsol does not modify the table.
//  Output latency: err_* are valid 1 cycle after the offending edge. Multiple codes in one cycle set all flags; err_code/err_source report the lowest code.
//  clear has priority over a new error on err_flags/err_count in the same cycle. The err_valid pulse is still emitted.
//  Burst counters are per channel (one open burst each); they wrap to 0 after the last beat.
//  inflight_count = allocations - retirements, updated every cycle; it never exceeds 2**SOURCE_W.
//  reset_n deasserted mid-burst: all state is discarded; the next beat is treated as a first beat.
// TESTING
//  Get src3 size2, then AccessAckData src3 size2 -> inflight 1 then 0; err_flags=0.
//  PutFull size4 (4 beats @LG_BEAT=2) with src changed on beat 2 -> err_code=5, err_source = new src, 1 cycle later.
//  A valid&!ready, address changes next cycle -> err_code=1, err_flags[0]=1 stays set until clear.
//  D AccessAck on idle src7 -> err_code=6, err_source=7, inflight stays 0.
//  TIMEOUT=16; Get src0 with no D -> err_code=9 on cycle 17 after the fire; err_count=1.
//  Same-cycle D last beat and new A Get on src2 -> no error, inflight unchanged at 1.

Source files
------------

// File: rtl/tl_inflight_monitor_if.sv
// TileLink-UL A/D link bundle observed by the in-flight monitor.
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both high; once valid is raised with ready low, the payload stays stable and
// valid stays high until the transfer happens.
interface tl_inflight_monitor_if #(
   parameter int SOURCE_W = 4,
   parameter int ADDR_W   = 30,
   parameter int SIZE_W   = 3
);
   logic                a_valid;
   logic                a_ready;
   logic [2:0]          a_opcode;
   logic [SIZE_W-1:0]   a_size;
   logic [SOURCE_W-1:0] a_source;
   logic [ADDR_W-1:0]   a_address;
   logic                d_valid;
   logic                d_ready;
   logic [2:0]          d_opcode;
   logic [SIZE_W-1:0]   d_size;
   logic [SOURCE_W-1:0] d_source;

   // Requester side: drives A, accepts D
   modport master (
      output a_valid, a_opcode, a_size, a_source, a_address, d_ready,
      input  a_ready, d_valid, d_opcode, d_size, d_source
   );

   // Responder side: accepts A, drives D
   modport slave (
      input  a_valid, a_opcode, a_size, a_source, a_address, d_ready,
      output a_ready, d_valid, d_opcode, d_size, d_source
   );

   // Passive observer of both channels
   modport monitor (
      input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
      input d_valid, d_ready, d_opcode, d_size, d_source
   );
endinterface

// File: rtl/tl_inflight_monitor.sv
// TileLink-UL in-flight request monitor: tracks outstanding requests per
// source, checks A stall stability, opcode legality, alignment, burst
// consistency, response matching, and a no-progress watchdog.
module tl_inflight_monitor #(
   parameter int SOURCE_W = 4,
   parameter int ADDR_W   = 30,
   parameter int SIZE_W   = 3,
   parameter int LG_BEAT  = 2,
   parameter int TIMEOUT  = 1024,
   parameter bit FATAL_EN = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   tl_inflight_monitor_if.monitor tl,
   input  logic                 clear,
   output logic                 err_valid,
   output logic [3:0]           err_code,
   output logic [SOURCE_W-1:0]  err_source,
   output logic [8:0]           err_flags,
   output logic [15:0]          err_count,
   output logic [SOURCE_W:0]    inflight_count
);
   localparam int ENTRIES = 2**SOURCE_W;
   // wide enough to hold the beat count of the largest transfer
   localparam int CNT_W   = 2**SIZE_W;
   localparam int WD_W    = $clog2(TIMEOUT + 2);

   function automatic logic [CNT_W-1:0] beats(input logic [SIZE_W-1:0] size);
      int sh;
      sh = int'(size) - LG_BEAT;
      if (sh <= 0) return CNT_W'(1);
      return CNT_W'(1) << sh;
   endfunction

   // tracking table
   logic [ENTRIES-1:0] tbl_v;
   logic [ENTRIES-1:0] tbl_data;
   logic [SIZE_W-1:0]  tbl_size [ENTRIES];

   // A stall hold register
   logic                hold_v;
   logic [2:0]          hold_op;
   logic [SIZE_W-1:0]   hold_size;
   logic [SOURCE_W-1:0] hold_src;
   logic [ADDR_W-1:0]   hold_addr;

   // per-channel open-burst state
   logic [CNT_W-1:0]    a_cnt, a_len_q;
   logic [2:0]          a_op_q;
   logic [SIZE_W-1:0]   a_size_q;
   logic [SOURCE_W-1:0] a_src_q;
   logic [CNT_W-1:0]    d_cnt, d_len_q;
   logic [2:0]          d_op_q;
   logic [SIZE_W-1:0]   d_size_q;
   logic [SOURCE_W-1:0] d_src_q;

   logic [WD_W-1:0]     wd;

   logic a_fire, d_fire, a_first, d_first, a_last, d_last, a_is_put;
   logic alloc, retire, wd_hit;
   logic [CNT_W-1:0]    a_len, d_len;
   logic [SOURCE_W-1:0] ret_src;
   logic [ADDR_W-1:0]   align_mask;
   logic [8:0]          e;
   logic [3:0]          code_c;
   logic [SOURCE_W-1:0] src_c;

   assign a_fire     = tl.a_valid & tl.a_ready;
   assign d_fire     = tl.d_valid & tl.d_ready;
   assign a_first    = (a_cnt == '0);
   assign d_first    = (d_cnt == '0);
   assign a_is_put   = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1);
   assign a_len      = a_is_put ? beats(tl.a_size) : CNT_W'(1);
   assign d_len      = (tl.d_opcode == 3'd1) ? beats(tl.d_size) : CNT_W'(1);
   assign a_last     = a_first ? (a_len == CNT_W'(1)) : (a_cnt + CNT_W'(1) == a_len_q);
   assign d_last     = d_first ? (d_len == CNT_W'(1)) : (d_cnt + CNT_W'(1) == d_len_q);
   // a D burst retires the source named on its first beat
   assign ret_src    = d_first ? tl.d_source : d_src_q;
   assign retire     = d_fire & d_last & tbl_v[ret_src];
   assign alloc      = a_fire & a_first;
   assign align_mask = (ADDR_W'(1) << tl.a_size) - ADDR_W'(1);
   assign wd_hit     = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT));

   // error detection for the current cycle; bit k-1 holds code k
   always_comb begin
      e = '0;
      e[0] = hold_v & (~tl.a_valid | (tl.a_opcode != hold_op) | (tl.a_size != hold_size) |
                       (tl.a_source != hold_src) | (tl.a_address != hold_addr));
      e[1] = alloc & ~(a_is_put | (tl.a_opcode == 3'd4));
      e[2] = alloc & ((tl.a_address & align_mask) != '0);
      e[3] = alloc & tbl_v[tl.a_source] & ~(retire & (ret_src == tl.a_source));
      e[4] = a_fire & ~a_first & ((tl.a_opcode != a_op_q) | (tl.a_size != a_size_q) |
                                  (tl.a_source != a_src_q));
      e[5] = d_fire & d_first & ~tbl_v[tl.d_source];
      e[6] = d_fire & d_first & tbl_v[tl.d_source] &
             ((tl.d_size != tbl_size[tl.d_source]) ||
              (tl.d_opcode != {2'b00, tbl_data[tl.d_source]}));
      e[7] = d_fire & ~d_first & ((tl.d_opcode != d_op_q) | (tl.d_size != d_size_q) |
                                  (tl.d_source != d_src_q));
      e[8] = wd_hit;
   end

   // lowest-numbered code wins; the watchdog is not tied to one source and reports 0
   always_comb begin
      code_c = 4'd0;
      src_c  = '0;
      if      (e[0]) begin code_c = 4'd1; src_c = hold_src;    end
      else if (e[1]) begin code_c = 4'd2; src_c = tl.a_source; end
      else if (e[2]) begin code_c = 4'd3; src_c = tl.a_source; end
      else if (e[3]) begin code_c = 4'd4; src_c = tl.a_source; end
      else if (e[4]) begin code_c = 4'd5; src_c = tl.a_source; end
      else if (e[5]) begin code_c = 4'd6; src_c = tl.d_source; end
      else if (e[6]) begin code_c = 4'd7; src_c = tl.d_source; end
      else if (e[7]) begin code_c = 4'd8; src_c = tl.d_source; end
      else if (e[8]) begin code_c = 4'd9; src_c = '0;          end
   end

   // capture a stalled A beat so the next cycle can be compared against it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_v    <= 1'b0;
         hold_op   <= '0;
         hold_size <= '0;
         hold_src  <= '0;
         hold_addr <= '0;
      end else begin
         hold_v    <= tl.a_valid & ~tl.a_ready;
         hold_op   <= tl.a_opcode;
         hold_size <= tl.a_size;
         hold_src  <= tl.a_source;
         hold_addr <= tl.a_address;
      end
   end

   // A burst beat counter with beat-0 fields for mid-burst comparison
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_cnt    <= '0;
         a_len_q  <= '0;
         a_op_q   <= '0;
         a_size_q <= '0;
         a_src_q  <= '0;
      end else if (a_fire) begin
         if (a_first) begin
            a_len_q  <= a_len;
            a_op_q   <= tl.a_opcode;
            a_size_q <= tl.a_size;
            a_src_q  <= tl.a_source;
            a_cnt    <= a_last ? '0 : CNT_W'(1);
         end else begin
            a_cnt <= a_last ? '0 : a_cnt + CNT_W'(1);
         end
      end
   end

   // D burst beat counter with beat-0 fields for mid-burst comparison
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d_cnt    <= '0;
         d_len_q  <= '0;
         d_op_q   <= '0;
         d_size_q <= '0;
         d_src_q  <= '0;
      end else if (d_fire) begin
         if (d_first) begin
            d_len_q  <= d_len;
            d_op_q   <= tl.d_opcode;
            d_size_q <= tl.d_size;
            d_src_q  <= tl.d_source;
            d_cnt    <= d_last ? '0 : CNT_W'(1);
         end else begin
            d_cnt <= d_last ? '0 : d_cnt + CNT_W'(1);
         end
      end
   end

   // tracking table: retire first, then allocate, so same-source reuse keeps the entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tbl_v    <= '0;
         tbl_data <= '0;
         for (int i = 0; i < ENTRIES; i++) tbl_size[i] <= '0;
      end else begin
         if (retire) tbl_v[ret_src] <= 1'b0;
         if (alloc) begin
            tbl_v[tl.a_source]    <= 1'b1;
            tbl_data[tl.a_source] <= (tl.a_opcode == 3'd4);
            tbl_size[tl.a_source] <= tl.a_size;
         end
      end
   end

   // outstanding count follows valid-entry transitions, so it cannot exceed the table size
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inflight_count <= '0;
      end else begin
         case ({alloc & ~tbl_v[tl.a_source], retire & ~(alloc & (tl.a_source == ret_src))})
            2'b10:   inflight_count <= inflight_count + 1'b1;
            2'b01:   inflight_count <= inflight_count - 1'b1;
            default: inflight_count <= inflight_count;
         endcase
      end
   end

   // no-progress watchdog: counts idle D cycles while requests are outstanding
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd <= '0;
      end else if ((TIMEOUT == 0) || d_fire || (inflight_count == '0) || wd_hit) begin
         wd <= '0;
      end else begin
         wd <= wd + 1'b1;
      end
   end

   // registered error reporting; clear beats new errors on flags/count but not the pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_valid  <= 1'b0;
         err_code   <= '0;
         err_source <= '0;
         err_flags  <= '0;
         err_count  <= '0;
      end else begin
         err_valid  <= |e;
         err_code   <= code_c;
         err_source <= src_c;
         if (clear) begin
            err_flags <= '0;
            err_count <= '0;
         end else begin
            err_flags <= err_flags | e;
            if ((|e) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
         end
      end
   end

`ifndef SYNTHESIS
   // optional hard stop on any detected protocol error
   always @(posedge clock) begin
      if (FATAL_EN && reset_n && (|e)) $fatal(1, "tl_inflight_monitor: error code %0d source %0d", code_c, src_c);
   end
`endif
endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor with hand-computed expectations.
module tb_tl_inflight_monitor;
   localparam int SOURCE_W = 4;
   localparam int ADDR_W   = 30;
   localparam int SIZE_W   = 3;

   logic                clock;
   logic                reset_n;
   logic                clear;
   logic                err_valid;
   logic [3:0]          err_code;
   logic [SOURCE_W-1:0] err_source;
   logic [8:0]          err_flags;
   logic [15:0]         err_count;
   logic [SOURCE_W:0]   inflight_count;

   int checks   = 0;
   int failures = 0;

   tl_inflight_monitor_if #(.SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

   tl_inflight_monitor #(
      .SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
      .LG_BEAT(2), .TIMEOUT(16), .FATAL_EN(1'b0)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .tl(bus),
      .clear(clear),
      .err_valid(err_valid),
      .err_code(err_code),
      .err_source(err_source),
      .err_flags(err_flags),
      .err_count(err_count),
      .inflight_count(inflight_count)
   );

   // clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // driver tasks: inputs change on the falling edge, DUT samples on the rising edge
   task automatic idle();
      bus.a_valid   = 1'b0;
      bus.a_ready   = 1'b1;
      bus.a_opcode  = 3'd0;
      bus.a_size    = '0;
      bus.a_source  = '0;
      bus.a_address = '0;
      bus.d_valid   = 1'b0;
      bus.d_ready   = 1'b1;
      bus.d_opcode  = 3'd0;
      bus.d_size    = '0;
      bus.d_source  = '0;
      clear         = 1'b0;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [SIZE_W-1:0] size,
                          input logic [SOURCE_W-1:0] src, input logic [ADDR_W-1:0] addr);
      bus.a_valid   = 1'b1;
      bus.a_opcode  = op;
      bus.a_size    = size;
      bus.a_source  = src;
      bus.a_address = addr;
   endtask

   task automatic drive_d(input logic [2:0] op, input logic [SIZE_W-1:0] size,
                          input logic [SOURCE_W-1:0] src);
      bus.d_valid  = 1'b1;
      bus.d_opcode = op;
      bus.d_size   = size;
      bus.d_source = src;
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
   endtask

   task automatic test_reset();
      idle();
      reset_n = 1'b0;
      step();
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL reset_err_valid actual=%0d expected=0", err_valid); end
      checks++; if (err_code !== 4'd0) begin failures++; $display("FAIL reset_err_code actual=%0d expected=0", err_code); end
      checks++; if (err_flags !== 9'd0) begin failures++; $display("FAIL reset_err_flags actual=%0h expected=0", err_flags); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count actual=%0d expected=0", err_count); end
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL reset_inflight actual=%0d expected=0", inflight_count); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_get_ack();
      drive_a(3'd4, 3'd2, 4'd3, 30'h100);
      step();
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL get_inflight1 actual=%0d expected=1", inflight_count); end
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL get_err_valid actual=%0d expected=0", err_valid); end
      idle();
      drive_d(3'd1, 3'd2, 4'd3);
      step();
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL ack_inflight0 actual=%0d expected=0", inflight_count); end
      checks++; if (err_flags !== 9'd0) begin failures++; $display("FAIL ack_err_flags actual=%0h expected=0", err_flags); end
      idle();
      step();
   endtask

   task automatic test_a_burst();
      drive_a(3'd0, 3'd4, 4'd5, 30'h40);
      step();
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL aburst_inflight actual=%0d expected=1", inflight_count); end
      drive_a(3'd0, 3'd4, 4'd5, 30'h40);
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL aburst_beat1 actual=%0d expected=0", err_valid); end
      drive_a(3'd0, 3'd4, 4'd6, 30'h40);
      step();
      checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL aburst_err_valid actual=%0d expected=1", err_valid); end
      checks++; if (err_code !== 4'd5) begin failures++; $display("FAIL aburst_code actual=%0d expected=5", err_code); end
      checks++; if (err_source !== 4'd6) begin failures++; $display("FAIL aburst_source actual=%0d expected=6", err_source); end
      drive_a(3'd0, 3'd4, 4'd5, 30'h40);
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL aburst_beat3 actual=%0d expected=0", err_valid); end
      checks++; if (err_flags !== 9'h010) begin failures++; $display("FAIL aburst_flags actual=%0h expected=10", err_flags); end
      idle();
      drive_d(3'd0, 3'd4, 4'd5);
      step();
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL aburst_retire actual=%0d expected=0", inflight_count); end
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL aburst_ack_err actual=%0d expected=0", err_valid); end
      do_clear();
   endtask

   task automatic test_stall();
      drive_a(3'd4, 3'd2, 4'd1, 30'h200);
      bus.a_ready = 1'b0;
      step();
      bus.a_address = 30'h204;
      step();
      checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL stall_err_valid actual=%0d expected=1", err_valid); end
      checks++; if (err_code !== 4'd1) begin failures++; $display("FAIL stall_code actual=%0d expected=1", err_code); end
      checks++; if (err_source !== 4'd1) begin failures++; $display("FAIL stall_source actual=%0d expected=1", err_source); end
      bus.a_ready = 1'b1;
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL stall_accept_err actual=%0d expected=0", err_valid); end
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL stall_inflight actual=%0d expected=1", inflight_count); end
      idle();
      step();
      step();
      checks++; if (err_flags[0] !== 1'b1) begin failures++; $display("FAIL stall_sticky actual=%0d expected=1", err_flags[0]); end
      drive_d(3'd1, 3'd2, 4'd1);
      clear = 1'b1;
      step();
      checks++; if (err_flags !== 9'd0) begin failures++; $display("FAIL stall_clear_flags actual=%0h expected=0", err_flags); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL stall_clear_count actual=%0d expected=0", err_count); end
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL stall_retire actual=%0d expected=0", inflight_count); end
      idle();
      step();
   endtask

   task automatic test_d_unsol();
      drive_d(3'd0, 3'd0, 4'd7);
      step();
      checks++; if (err_code !== 4'd6) begin failures++; $display("FAIL unsol_code actual=%0d expected=6", err_code); end
      checks++; if (err_source !== 4'd7) begin failures++; $display("FAIL unsol_source actual=%0d expected=7", err_source); end
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL unsol_inflight actual=%0d expected=0", inflight_count); end
      do_clear();
   endtask

   task automatic test_a_checks();
      drive_a(3'd4, 3'd2, 4'd4, 30'h2);
      step();
      checks++; if (err_code !== 4'd3) begin failures++; $display("FAIL align_code actual=%0d expected=3", err_code); end
      checks++; if (err_source !== 4'd4) begin failures++; $display("FAIL align_source actual=%0d expected=4", err_source); end
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL align_inflight actual=%0d expected=1", inflight_count); end
      drive_a(3'd4, 3'd2, 4'd4, 30'h0);
      step();
      checks++; if (err_code !== 4'd4) begin failures++; $display("FAIL dup_code actual=%0d expected=4", err_code); end
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL dup_inflight actual=%0d expected=1", inflight_count); end
      drive_a(3'd3, 3'd2, 4'd9, 30'h3);
      step();
      checks++; if (err_code !== 4'd2) begin failures++; $display("FAIL opcode_code actual=%0d expected=2", err_code); end
      checks++; if (err_source !== 4'd9) begin failures++; $display("FAIL opcode_source actual=%0d expected=9", err_source); end
      checks++; if (inflight_count !== 5'd2) begin failures++; $display("FAIL opcode_inflight actual=%0d expected=2", inflight_count); end
      idle();
      drive_d(3'd0, 3'd2, 4'd4);
      step();
      checks++; if (err_code !== 4'd7) begin failures++; $display("FAIL dmis_code actual=%0d expected=7", err_code); end
      checks++; if (err_flags !== 9'h04E) begin failures++; $display("FAIL dmis_flags actual=%0h expected=4e", err_flags); end
      checks++; if (err_count !== 16'd4) begin failures++; $display("FAIL dmis_count actual=%0d expected=4", err_count); end
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL dmis_inflight actual=%0d expected=1", inflight_count); end
      drive_d(3'd0, 3'd2, 4'd9);
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL ack9_err actual=%0d expected=0", err_valid); end
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL ack9_inflight actual=%0d expected=0", inflight_count); end
      do_clear();
   endtask

   task automatic test_d_burst();
      drive_a(3'd4, 3'd4, 4'd8, 30'h10);
      step();
      idle();
      drive_d(3'd1, 3'd4, 4'd8);
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL dburst_beat0 actual=%0d expected=0", err_valid); end
      drive_d(3'd1, 3'd4, 4'd9);
      step();
      checks++; if (err_code !== 4'd8) begin failures++; $display("FAIL dburst_code actual=%0d expected=8", err_code); end
      checks++; if (err_source !== 4'd9) begin failures++; $display("FAIL dburst_source actual=%0d expected=9", err_source); end
      drive_d(3'd1, 3'd4, 4'd8);
      step();
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL dburst_midinflight actual=%0d expected=1", inflight_count); end
      drive_d(3'd1, 3'd4, 4'd8);
      step();
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL dburst_retire actual=%0d expected=0", inflight_count); end
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL dburst_last actual=%0d expected=0", err_valid); end
      do_clear();
   endtask

   task automatic test_timeout();
      drive_a(3'd4, 3'd2, 4'd0, 30'h0);
      step();
      idle();
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k < 17) begin
            checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL timeout_early cycle=%0d actual=%0d expected=0", k, err_valid); end
         end
      end
      checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL timeout_valid actual=%0d expected=1", err_valid); end
      checks++; if (err_code !== 4'd9) begin failures++; $display("FAIL timeout_code actual=%0d expected=9", err_code); end
      checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL timeout_count actual=%0d expected=1", err_count); end
      drive_d(3'd1, 3'd2, 4'd0);
      step();
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL timeout_retire actual=%0d expected=0", inflight_count); end
      do_clear();
   endtask

   task automatic test_back_to_back();
      drive_a(3'd4, 3'd2, 4'd2, 30'h20);
      step();
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL b2b_inflight_a actual=%0d expected=1", inflight_count); end
      drive_a(3'd4, 3'd2, 4'd2, 30'h24);
      drive_d(3'd1, 3'd2, 4'd2);
      step();
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL b2b_err actual=%0d expected=0", err_valid); end
      checks++; if (inflight_count !== 5'd1) begin failures++; $display("FAIL b2b_inflight_b actual=%0d expected=1", inflight_count); end
      idle();
      drive_d(3'd1, 3'd2, 4'd2);
      step();
      checks++; if (inflight_count !== 5'd0) begin failures++; $display("FAIL b2b_retire actual=%0d expected=0", inflight_count); end
      checks++; if (err_flags !== 9'd0) begin failures++; $display("FAIL b2b_flags actual=%0h expected=0", err_flags); end
      idle();
      step();
   endtask

   // sequence of directed scenarios and final report
   initial begin
      test_reset();
      test_get_ack();
      test_a_burst();
      test_stall();
      test_d_unsol();
      test_a_checks();
      test_d_burst();
      test_timeout();
      test_back_to_back();
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
